// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 16x8 FIFO: drains a requested word count,
// hides the one-cycle RAM read latency in a 2-entry skid buffer, and streams it out.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN_W-1:0] words_out
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] remaining;
  logic             pend;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head, tail;
  logic             pop, credit, done_next, load;
  logic [2:0]       inflight;

  // A read may only issue if the word it returns is guaranteed a skid slot.
  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    done_next  = 1'b0;
    load       = 1'b0;
    pop        = (occ != 2'd0) && out_ready;
    inflight   = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    credit     = (inflight < 3'd2);
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_next = RUN;
            load       = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        fifo_read = !fifo_empty && (remaining != '0) && credit;
        if (fifo_read && (remaining == LEN_W'(1)))
          state_next = FLUSH;
      end
      FLUSH: begin
        if (!pend && (occ == 2'd0)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: burst counters plus the skid buffer (head is the visible word).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      pend      <= 1'b0;
      remaining <= '0;
      words_out <= '0;
      occ       <= 2'd0;
      head      <= '0;
      tail      <= '0;
    end else begin
      done <= done_next;
      pend <= fifo_read;
      if (load)
        remaining <= len;
      else if (fifo_read)
        remaining <= remaining - LEN_W'(1);
      if (load)
        words_out <= '0;
      else if (pop && (words_out != '1))
        words_out <= words_out + LEN_W'(1);
      case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) head <= fifo_data;
          else             tail <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= fifo_data;
          end else begin
            head <= tail;
            tail <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = head;
  assign out_valid = (occ != 2'd0);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO with registered read data,
// scoreboard queue of expected stream words checked on every downstream transfer.
module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy, done;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_read;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] words_out;

  int total = 0;
  int bad = 0;
  int read_count = 0;
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];

  fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .words_out(words_out)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, empty flag updated on the clock.
  always @(posedge clk) begin
    if (fifo_read) begin
      read_count++;
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard: every downstream transfer must match the next expected word.
  always begin
    logic [WIDTH-1:0] exp_word;
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL stream_extra got=%h expected=none", out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (out_data !== exp_word) begin
          bad++;
          $display("[TB] FAIL stream_data got=%h expected=%h", out_data, exp_word);
        end
      end
    end
  end

  task automatic load_fifo(input logic [WIDTH-1:0] first, input int n, input int n_exp);
    for (int i = 0; i < n; i++) begin
      fq.push_back(first + WIDTH'(i));
      if (i < n_exp) exp_q.push_back(first + WIDTH'(i));
    end
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, fifo_read, out_valid, out_data, words_out} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b required=0",
               {busy, done, fifo_read, out_valid, out_data, words_out});
    end
    reset = 1'b0;
    @(negedge clk);
    read_count = 0;
    pulse_start(5'd0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len0_done got done=%b busy=%b required done=1 busy=0", done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || read_count != 0) begin
      bad++;
      $display("[TB] FAIL len0_after got done=%b reads=%0d required done=0 reads=0", done, read_count);
    end
  endtask

  task automatic test_burst();
    bit seen;
    load_fifo(8'h01, 4, 4);
    out_ready = 1'b1;
    @(negedge clk);
    read_count = 0;
    pulse_start(5'd4);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL burst_latency got valid=%b busy=%b required valid=0 busy=1", out_valid, busy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL burst_consecutive got valid=%b required=1 at word %0d", out_valid, k);
      end
    end
    wait_done(40, seen);
    total++;
    if (!seen || busy !== 1'b0 || words_out !== 5'd4 || read_count != 4) begin
      bad++;
      $display("[TB] FAIL burst_done got done=%b busy=%b words=%0d reads=%0d required 1,0,4,4",
               seen, busy, words_out, read_count);
    end
  endtask

  task automatic test_stall();
    bit seen;
    load_fifo(8'h0a, 6, 6);
    out_ready = 1'b0;
    @(negedge clk);
    read_count = 0;
    pulse_start(5'd6);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h0a) begin
        bad++;
        $display("[TB] FAIL stall_hold got valid=%b data=%h required valid=1 data=0a", out_valid, out_data);
      end
    end
    total++;
    if (read_count != 2) begin
      bad++;
      $display("[TB] FAIL stall_reads got=%0d required=2", read_count);
    end
    out_ready = 1'b1;
    wait_done(40, seen);
    total++;
    if (!seen || words_out !== 5'd6 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL stall_done got done=%b words=%0d left=%0d required 1,6,0",
               seen, words_out, exp_q.size());
    end
  endtask

  task automatic test_empty();
    bit seen;
    load_fifo(8'h21, 2, 2);
    out_ready = 1'b1;
    @(negedge clk);
    read_count = 0;
    pulse_start(5'd4);
    repeat (8) @(negedge clk);
    total++;
    if (read_count != 2 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL empty_stall got reads=%0d busy=%b done=%b required 2,1,0", read_count, busy, done);
    end
    fq.push_back(8'h33); exp_q.push_back(8'h33);
    fq.push_back(8'h44); exp_q.push_back(8'h44);
    wait_done(40, seen);
    total++;
    if (!seen || read_count != 4 || words_out !== 5'd4 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL empty_resume got done=%b reads=%0d words=%0d left=%0d required 1,4,4,0",
               seen, read_count, words_out, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    load_fifo(8'h51, 5, 3);
    out_ready = 1'b1;
    @(negedge clk);
    read_count = 0;
    pulse_start(5'd3);
    pulse_start(5'd7);
    pulse_start(5'd9);
    wait_done(40, seen);
    total++;
    if (!seen || read_count != 3 || words_out !== 5'd3 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL restart_ignored got done=%b reads=%0d words=%0d left=%0d required 1,3,3,0",
               seen, read_count, words_out, exp_q.size());
    end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || read_count != 3) begin
      bad++;
      $display("[TB] FAIL restart_idle got busy=%b reads=%0d required busy=0 reads=3", busy, read_count);
    end
    fq.delete();
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_fifo(8'h61, 5, 5);
    out_ready = 1'b1;
    @(negedge clk);
    pulse_start(5'd5);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (words_out == 5'd2) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL midreset_progress got words=%0d required=2", words_out);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, fifo_read, out_valid, out_data, words_out} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_async got=%b required=0",
               {busy, done, fifo_read, out_valid, out_data, words_out});
    end
    exp_q.delete();
    fq.delete();
    @(negedge clk);
    reset = 1'b0;
    wait_done(6, seen);
    total++;
    if (seen || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_idle got done=%b busy=%b required done=0 busy=0", seen, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    len = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_burst();
    test_stall();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
